// File: rtl/subpel_pkg.sv
// subpel_pkg: phase codes, 8-tap HEVC luma filter coefficients, rounding and clipping helpers
package subpel_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  typedef logic signed [7:0] coef_t;
  localparam logic [1:0] FRAC_FULL = 2'd0;
  localparam logic [1:0] FRAC_QTR = 2'd1;
  localparam logic [1:0] FRAC_HALF = 2'd2;
  localparam logic [1:0] FRAC_3QTR = 2'd3;
  localparam int ROUND_OFS = 32;
  localparam int SHIFT = 6;
  localparam coef_t COEF_A [8] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam coef_t COEF_B [8] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam coef_t COEF_C [8] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
  // Full phase reuses the FIR datapath as a unit impulse of weight 64 on tap 3
  function automatic coef_t coef(input logic [1:0] frac, input logic [2:0] k);
    return frac == FRAC_QTR ? COEF_A[k] : frac == FRAC_HALF ? COEF_B[k] :
           frac == FRAC_3QTR ? COEF_C[k] : (k == 3'd3 ? 8'sd64 : 8'sd0);
  endfunction
  function automatic int clip_pix(input int v, input int maxv);
    return v < 0 ? 0 : v > maxv ? maxv : v;
  endfunction
endpackage

// File: rtl/subpel_fir_lane.sv
// subpel_fir_lane: one interpolated pixel, 8-tap FIR with products/pair sums in S1 and
// final sum/round/clip in S2, both stages gated by the shared pipeline enable
module subpel_fir_lane
  import subpel_pkg::*;
#(
  parameter int BITDEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [8*BITDEPTH-1:0] pix,
  input  logic [1:0]            frac,
  output logic [BITDEPTH-1:0]   res
);
  localparam int SW = BITDEPTH + 8;
  localparam int MAXV = (1 << BITDEPTH) - 1;
  logic signed [SW-1:0] prod [8];
  logic signed [SW-1:0] part [4];
  logic signed [SW-1:0] sum, rnd;
  for (genvar k = 0; k < 8; k++) begin : g_tap
    coef_t c;
    assign c = coef(frac, 3'(k));
    assign prod[k] = $signed({8'd0, pix[k*BITDEPTH +: BITDEPTH]}) * SW'(c);
  end
  assign sum = part[0] + part[1] + part[2] + part[3];
  assign rnd = (sum + SW'(ROUND_OFS)) >>> SHIFT;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) part[i] <= '0;
      res <= '0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) part[i] <= prod[2*i] + prod[2*i+1];
      res <= BITDEPTH'(clip_pix(int'(rnd), MAXV));
    end
  end
endmodule

// File: rtl/subpel_row_interp_stream.sv
// subpel_row_interp_stream: streaming horizontal subpel row filter with block framing and backpressure.
// Define SUBPEL_ALL_PHASES_EN to add out_all carrying the {C,B,A} filtered rows alongside out_row.
module subpel_row_interp_stream
  import subpel_pkg::*;
#(
  parameter int NUM_PIX  = 8,
  parameter int BITDEPTH = 8,
  parameter int BLK_H    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [(NUM_PIX+7)*BITDEPTH-1:0] in_row,
  input  logic [1:0]                      in_frac,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_PIX*BITDEPTH-1:0]     out_row,
  output logic [1:0]                      out_frac,
  output logic                            out_last,
  output logic                            busy
`ifdef SUBPEL_ALL_PHASES_EN
  ,
  output logic [3*NUM_PIX*BITDEPTH-1:0]   out_all
`endif
);
  localparam int CW = BLK_H > 1 ? $clog2(BLK_H) : 1;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] frac_q, frac_d, tag_frac, f1;
  logic en, acc, tag_last, v1, l1, v2;
  assign en = !v2 || out_ready;
  assign in_ready = en;
  assign acc = in_valid && en;
  assign out_valid = v2;
  assign busy = state == RUN || v1 || v2;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    frac_d = frac_q;
    tag_frac = frac_q;
    tag_last = 1'b0;
    if (acc && state == IDLE) begin
      frac_d = in_frac;
      tag_frac = in_frac;
      tag_last = BLK_H == 1;
      if (BLK_H > 1) begin
        state_d = RUN;
        cnt_d = CW'(1);
      end
    end else if (acc) begin
      tag_last = cnt == CW'(BLK_H - 1);
      cnt_d = tag_last ? '0 : cnt + CW'(1);
      if (tag_last) state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      frac_q <= '0;
      v1 <= 1'b0;
      f1 <= '0;
      l1 <= 1'b0;
      v2 <= 1'b0;
      out_frac <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      frac_q <= frac_d;
      if (en) begin
        v1 <= acc;
        f1 <= tag_frac;
        l1 <= tag_last;
        v2 <= v1;
        out_frac <= f1;
        out_last <= l1;
      end
    end
  end
  for (genvar j = 0; j < NUM_PIX; j++) begin : g_pix
    subpel_fir_lane #(.BITDEPTH(BITDEPTH)) u_lane (
      .clk(clk), .rst(rst), .en(en),
      .pix(in_row[j*BITDEPTH +: 8*BITDEPTH]),
      .frac(tag_frac),
      .res(out_row[j*BITDEPTH +: BITDEPTH])
    );
`ifdef SUBPEL_ALL_PHASES_EN
    for (genvar p = 0; p < 3; p++) begin : g_ph
      subpel_fir_lane #(.BITDEPTH(BITDEPTH)) u_fixed (
        .clk(clk), .rst(rst), .en(en),
        .pix(in_row[j*BITDEPTH +: 8*BITDEPTH]),
        .frac(2'(p + 1)),
        .res(out_all[(p*NUM_PIX+j)*BITDEPTH +: BITDEPTH])
      );
    end
`endif
  end
endmodule

// File: tb/tb_subpel_row_interp_stream.sv
// tb_subpel_row_interp_stream: directed and random rows against an arithmetic tap model and
// a block-framing scoreboard
module tb_subpel_row_interp_stream;
  localparam int NP = 8;
  localparam int BD = 8;
  localparam int BH = 4;
  localparam int ROW_W = (NP + 7) * BD;
  localparam int OW = NP * BD;
  typedef struct {
    logic [OW-1:0] row;
    logic [1:0]    frac;
    logic          last;
  } exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [ROW_W-1:0] in_row;
  logic [1:0] in_frac, out_frac;
  logic [OW-1:0] out_row;
  int checks = 0;
  int failures = 0;
  int blk_pos = 0;
  int last_cnt = 0;
  int n_acc = 0;
  logic [1:0] blk_frac = 2'd0;
  exp_t exp_q [$];
  int taps [4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                      '{-1, 4, -10, 58, 17, -5, 1, 0},
                      '{-1, 4, -11, 40, 40, -11, 4, -1},
                      '{0, 1, -5, 17, 58, -10, 4, -1}};

  subpel_row_interp_stream #(.NUM_PIX(NP), .BITDEPTH(BD), .BLK_H(BH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_frac(in_frac), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_frac(out_frac), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_row(input logic [ROW_W-1:0] r, input logic [1:0] f);
    logic [OW-1:0] o;
    int s, p;
    o = '0;
    for (int j = 0; j < NP; j++) begin
      if (f == 2'd0) p = int'(r[(j+3)*BD +: BD]);
      else begin
        s = 0;
        for (int k = 0; k < 8; k++) s += taps[f][k] * int'(r[(j+k)*BD +: BD]);
        p = (s + 32) >>> 6;
        p = p < 0 ? 0 : p > (1 << BD) - 1 ? (1 << BD) - 1 : p;
      end
      o[j*BD +: BD] = p[BD-1:0];
    end
    return o;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < NP + 7; k++) r[k*BD +: BD] = BD'($urandom);
    return r;
  endfunction

  // One clock: drive, score any output handed off this cycle, model any accepted beat
  task automatic cyc(input logic v, input logic [ROW_W-1:0] row, input logic [1:0] fr,
                     input logic ordy);
    exp_t e;
    logic acc;
    in_valid = v;
    in_row = row;
    in_frac = fr;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) chk("spurious_out", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("out_row", out_row, e.row);
        chk("out_frac", 64'(out_frac), 64'(e.frac));
        chk("out_last", 64'(out_last), 64'(e.last));
        if (out_last) last_cnt++;
      end
    end
    if (acc) begin
      if (blk_pos == 0) blk_frac = fr;
      e.row = model_row(row, blk_frac);
      e.frac = blk_frac;
      e.last = blk_pos == BH - 1;
      exp_q.push_back(e);
      blk_pos = (blk_pos + 1) % BH;
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    blk_pos = 0;
    last_cnt = 0;
    n_acc = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b0, '0, 2'd0, 1'b1);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [ROW_W-1:0] r;
    logic [OW-1:0] held, m;
    logic [1:0] fr;
    rst = 1'b0;
    in_valid = 1'b0;
    in_row = '0;
    in_frac = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_row", out_row, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_frac", 64'(out_frac), 64'd0);
    rst = 1'b1;
    #1 chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Ramp half-pel: latency and the known 35
    for (int k = 0; k < NP + 7; k++) r[k*BD +: BD] = BD'(10 * k);
    cyc(1'b1, r, 2'd2, 1'b1);
    chk("lat1_valid", 64'(out_valid), 64'd0);
    chk("busy_run", 64'(busy), 64'd1);
    cyc(1'b0, '0, 2'd0, 1'b1);
    chk("lat2_valid", 64'(out_valid), 64'd1);
    chk("ramp_pix0", 64'(out_row[7:0]), 64'd35);
    drain("ramp_drain");
    // Flat 255 at every phase
    for (int f = 0; f < 4; f++) begin
      hard_reset();
      r = '1;
      cyc(1'b1, r, 2'(f), 1'b1);
      cyc(1'b0, '0, 2'd0, 1'b1);
      chk("flat_row", out_row, {NP{8'hff}});
      drain("flat_drain");
    end
    // Full phase passes pixel j+3
    hard_reset();
    r = rand_row();
    cyc(1'b1, r, 2'd0, 1'b1);
    cyc(1'b0, '0, 2'd0, 1'b1);
    chk("full_pass", out_row, r[3*BD +: OW]);
    drain("full_drain");
    // Impulse at pixel 3, quarter phase
    hard_reset();
    r = '0;
    r[3*BD +: BD] = 8'd255;
    m = model_row(r, 2'd1);
    cyc(1'b1, r, 2'd1, 1'b1);
    cyc(1'b0, '0, 2'd0, 1'b1);
    chk("imp_pix0", 64'(out_row[7:0]), 64'(m[7:0]));
    chk("imp_pix3", 64'(out_row[31:24]), 64'd0);
    drain("imp_drain");
    // Two back-to-back blocks, frac toggled inside each
    hard_reset();
    for (int i = 0; i < 8; i++) begin
      fr = (i == 0) ? 2'd1 : (i == 4) ? 2'd3 : 2'(i % 3);
      cyc(1'b1, rand_row(), fr, 1'b1);
    end
    chk("frame_acc", 64'(n_acc), 64'd8);
    drain("frame_drain");
    chk("frame_lasts", 64'(last_cnt), 64'd2);
    chk("frame_idle", 64'(busy), 64'd0);
    // Output stall for 5 cycles mid-stream
    hard_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, rand_row(), 2'(i), 1'b1);
    held = out_row;
    chk("pre_stall_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, rand_row(), 2'd1, 1'b0);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", out_row, held);
    end
    for (int i = 0; i < 6; i++) cyc(1'b1, rand_row(), 2'd2, 1'b1);
    drain("stall_drain");
    // Random traffic with random backpressure
    hard_reset();
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 3) != 0, rand_row(), 2'($urandom), $urandom_range(0, 9) < 7);
    drain("rand_drain");
    chk("rand_count", 64'(n_acc > 40), 64'd1);
    // Asynchronous reset with both stages full, mid-block
    hard_reset();
    cyc(1'b1, rand_row(), 2'd2, 1'b1);
    cyc(1'b1, rand_row(), 2'd2, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_row", out_row, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    blk_pos = 0;
    last_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 2'd0, 1'b1);
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    for (int i = 0; i < BH; i++) cyc(1'b1, rand_row(), (i == 0) ? 2'd3 : 2'd1, 1'b1);
    drain("post_rst_drain");
    chk("post_rst_lasts", 64'(last_cnt), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
